// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad front end: scanner states, key indices
// and the default key-code width.
package keypad_pkg;

  localparam int unsigned KEY_CODE_W = 5;

  localparam int unsigned KEY_RSHIFT = 17;
  localparam int unsigned KEY_LSHIFT = 18;
  localparam int unsigned KEY_CLR    = 19;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    HELD,
    RELEASE
  } kp_state_e;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pb_sync.sv
// Two-flop synchronizer for asynchronous level inputs, async active-low reset.
module pb_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             CLK,
  input  logic             NRST,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s0_q;
  logic [WIDTH-1:0] s1_q;

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      s0_q <= '0;
      s1_q <= '0;
    end else begin
      s0_q <= d;
      s1_q <= s0_q;
    end
  end

  assign q = s1_q;

endmodule

// File: rtl/key_scanner.sv
// Push-button front end: synchronize, debounce and priority-encode the button
// bus, emitting one strobe per press plus optional auto-repeat while held.
module key_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned NUM_KEYS     = 21,
  parameter int unsigned CODE_W       = KEY_CODE_W,
  parameter int unsigned DEBOUNCE_CYC = 2,
  parameter int unsigned REPEAT_EN    = 1,
  parameter int unsigned REPEAT_DELAY = 50,
  parameter int unsigned REPEAT_RATE  = 10
) (
  input  logic                CLK,
  input  logic                NRST,
  input  logic [NUM_KEYS-1:0] pb,
  output logic                key_strobe,
  output logic [CODE_W-1:0]   key_code,
  output logic                key_repeat,
  output logic                key_down,
  output logic                multi_press
);

  localparam int unsigned CNT_W  = cnt_w(DEBOUNCE_CYC);
  localparam int unsigned RMAX   = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RCNT_W = cnt_w(RMAX);

  localparam logic [CNT_W-1:0]  DEB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [RCNT_W-1:0] DELAY_LAST = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] RATE_LAST  = RCNT_W'(REPEAT_RATE - 1);

  logic [NUM_KEYS-1:0] sync_pb;

  pb_sync #(.WIDTH(NUM_KEYS)) u_pb_sync (
    .CLK  (CLK),
    .NRST (NRST),
    .d    (pb),
    .q    (sync_pb)
  );

  kp_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
  logic              rep_phase_q, rep_phase_d;
  logic [CODE_W-1:0] key_code_q, key_code_d;
  logic              key_strobe_q, key_strobe_d;
  logic              key_repeat_q, key_repeat_d;

  logic [CODE_W-1:0] cand;
  logic              any_key;
  logic              key_hit;
  logic              multi;
  logic [RCNT_W-1:0] rep_target;

  // Lowest set index wins.
  always_comb begin
    logic found;
    cand  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (sync_pb[i] && !found) begin
        cand  = CODE_W'(i);
        found = 1'b1;
      end
    end
  end

  assign any_key    = |sync_pb;
  assign key_hit    = |(sync_pb & (NUM_KEYS'(1) << key_code_q));
  assign multi      = |(sync_pb & (sync_pb - NUM_KEYS'(1)));
  assign rep_target = rep_phase_q ? RATE_LAST : DELAY_LAST;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rcnt_d       = rcnt_q;
    rep_phase_d  = rep_phase_q;
    key_code_d   = key_code_q;
    key_strobe_d = 1'b0;
    key_repeat_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_key) begin
          key_code_d = cand;
          cnt_d      = '0;
          state_d    = DEBOUNCE;
        end
      end

      DEBOUNCE: begin
        if (!key_hit) begin
          state_d = IDLE;
        end else if (cnt_q == DEB_LAST) begin
          state_d      = HELD;
          key_strobe_d = 1'b1;
          rcnt_d       = '0;
          rep_phase_d  = 1'b0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      HELD: begin
        // Release is checked first so it suppresses a repeat due on the same cycle.
        if (!key_hit) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end else if ((REPEAT_EN != 0) && (rcnt_q == rep_target)) begin
          key_strobe_d = 1'b1;
          key_repeat_d = 1'b1;
          rcnt_d       = '0;
          rep_phase_d  = 1'b1;
        end else if (rcnt_q != '1) begin
          rcnt_d = rcnt_q + RCNT_W'(1);
        end
      end

      RELEASE: begin
        if (any_key) begin
          cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rcnt_q       <= '0;
      rep_phase_q  <= 1'b0;
      key_code_q   <= '0;
      key_strobe_q <= 1'b0;
      key_repeat_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rcnt_q       <= rcnt_d;
      rep_phase_q  <= rep_phase_d;
      key_code_q   <= key_code_d;
      key_strobe_q <= key_strobe_d;
      key_repeat_q <= key_repeat_d;
    end
  end

  assign key_strobe  = key_strobe_q;
  assign key_code    = key_code_q;
  assign key_repeat  = key_repeat_q;
  assign key_down    = (state_q == HELD);
  assign multi_press = key_down & multi;

endmodule
